// File: rtl/generator_caller_pkg.sv
// Shared types for generator_caller: FSM state encoding and the yield-pair record
// stored in the result FIFO (fields sized for the widest supported WIDTH).
package generator_caller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned YIELD_W_MAX = 64;

  typedef struct packed {
    logic signed [YIELD_W_MAX-1:0] out0;
    logic signed [YIELD_W_MAX-1:0] out1;
  } yield_pair_t;

endpackage

// File: rtl/generator_caller_fifo.sv
// First-word fall-through FIFO of yield pairs; pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module generator_caller_fifo
  import generator_caller_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic signed [WIDTH-1:0] din0,
  input  logic signed [WIDTH-1:0] din1,
  input  logic                    pop,
  output logic                    full,
  output logic                    empty,
  output logic signed [WIDTH-1:0] dout0,
  output logic signed [WIDTH-1:0] dout1
);

  localparam int unsigned AW = $clog2(DEPTH);

  yield_pair_t     mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     count;
  yield_pair_t     head;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: reads are only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= '{out0: YIELD_W_MAX'(din0), out1: YIELD_W_MAX'(din1)};
    end
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign dout0 = WIDTH'(head.out0);
  assign dout1 = WIDTH'(head.out1);

endmodule

// File: rtl/generator_caller.sv
// generator_caller: launches one generator call, buffers its yields in order and
// pulses call_done once drained. Watchdog enabled by GENERATOR_CALLER_TIMEOUT_EN.
module generator_caller
  import generator_caller_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [WIDTH-1:0] cmd_a,
  input  logic signed [WIDTH-1:0] cmd_b,
  input  logic signed [WIDTH-1:0] cmd_c,
  input  logic signed [WIDTH-1:0] cmd_d,
  output logic                    _start,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] _out0,
  input  logic signed [WIDTH-1:0] _out1,
  input  logic                    _valid,
  output logic                    _ready,
  input  logic                    _done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH-1:0] res_out0,
  output logic signed [WIDTH-1:0] res_out1,
  output logic                    call_done,
  output logic [15:0]             yield_count,
  output logic                    timeout_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 ||
      WIDTH < 1 || WIDTH > YIELD_W_MAX) begin : g_bad_params
    $error("generator_caller: illegal parameter set");
  end

  state_t state_q, state_d;
  logic   first_run_q;
  logic   cmd_fire, push, pop;
  logic   fifo_full, fifo_empty;
  logic   timeout_hit;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign push      = _valid && _ready;
  assign pop       = res_valid && res_ready;
  assign res_valid = !fifo_empty;

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q     <= IDLE;
      first_run_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_run_q <= (state_q == START);
    end
  end

  // _done is masked until the second RUN cycle so a stale done from the
  // previous call cannot end this one early.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    _start    = 1'b0;
    _ready    = 1'b0;
    call_done = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = START;
      end
      START: begin
        _start  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        _ready = !fifo_full;
        if ((_done && !first_run_q) || timeout_hit) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          call_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      yield_count <= '0;
    end else if (cmd_fire) begin
      a           <= cmd_a;
      b           <= cmd_b;
      c           <= cmd_c;
      d           <= cmd_d;
      yield_count <= '0;
    end else if (push && yield_count != 16'hFFFF) begin
      yield_count <= yield_count + 16'd1;
    end
  end

`ifdef GENERATOR_CALLER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign timeout_hit = (state_q == RUN) && !push && !_done &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != RUN || push || _done) wd_cnt <= '0;
      else                                 wd_cnt <= wd_cnt + WD_W'(1);
      if (cmd_fire)         timeout_q <= 1'b0;
      else if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  generator_caller_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (_clock),
    .rst_n (_reset_n),
    .push  (push),
    .din0  (_out0),
    .din1  (_out1),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout0 (res_out0),
    .dout1 (res_out1)
  );

endmodule

// File: doc/generator_caller.md
GENERATOR_CALLER -- requirements
Module: generator_caller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the signed width of arguments and yielded values.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of result FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the watchdog limit in cycles.
REQ-004 SHALL have port _clock  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port _reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid/cmd_ready  in/out  1/1  call request handshake.
REQ-007 SHALL have port cmd_a, cmd_b, cmd_c, cmd_d  in  WIDTH signed  call arguments.
REQ-008 SHALL have port _start  out  1  one-cycle start pulse to the generator.
REQ-009 SHALL have port a, b, c, d  out  WIDTH signed  arguments to the generator, held for the whole call.
REQ-010 SHALL have port _out0, _out1  in  WIDTH signed  yielded values from the generator.
REQ-011 SHALL have port _valid/_ready  in/out  1/1  yield handshake; a yield transfers when both are high.
REQ-012 SHALL have port _done  in  1  generator completion.
REQ-013 SHALL have port res_valid/res_ready  out/in  1/1  result stream handshake.
REQ-014 SHALL have port res_out0, res_out1  out  WIDTH signed  buffered yields, in order.
REQ-015 SHALL have port call_done  out  1  one-cycle completion pulse.
REQ-016 SHALL have port yield_count  out  16  number of yields accepted in the current or last call.
REQ-017 SHALL have port timeout_err  out  1  sticky watchdog error (REQ-030).

Function
REQ-018 SHALL implement the FSM states IDLE -> START -> RUN -> DRAIN -> IDLE.
REQ-019 IDLE: cmd_ready=1; on a cmd handshake, capture the args into a..d, clear yield_count, go to START.
REQ-020 START: assert _start for exactly one cycle, then go to RUN; cmd_ready=0 in all states except IDLE.
REQ-021 RUN: _ready = FIFO not full (no same-cycle pop credit); each _valid&&_ready pushes {_out0,_out1} and increments yield_count, saturating at 16'hFFFF.
REQ-022 RUN: ignore _done in the START cycle and the first RUN cycle; thereafter _done moves the FSM to DRAIN.
REQ-023 When _valid, _ready and _done are high in the same cycle, SHALL accept the yield, then go to DRAIN.
REQ-024 DRAIN: _ready=0; when the FIFO is empty, pulse call_done for one cycle and go to IDLE.
REQ-025 The FIFO SHALL be first-word fall-through: res_valid = not empty; pop on res_valid&&res_ready.
REQ-026 On push and pop in the same cycle, occupancy SHALL be unchanged; pointers SHALL wrap modulo DEPTH.
REQ-027 Arithmetic SHALL be pass-through with no width change; yield_count SHALL be unsigned.

Reset
REQ-028 When _reset_n is low, SHALL go to IDLE and empty the FIFO; _start, _ready, res_valid, call_done, timeout_err, yield_count, a..d SHALL be 0; cmd_ready SHALL be 1.
REQ-029 Reset asserted mid-call SHALL abandon the call without a call_done pulse; buffered results are discarded.

Configuration
REQ-030 With GENERATOR_CALLER_TIMEOUT_EN defined, SHALL count cycles in RUN without a yield or _done and reset the count on each yield; at TIMEOUT_CYCLES, SHALL set timeout_err and go to DRAIN; timeout_err SHALL clear on the next cmd handshake.
REQ-031 Without GENERATOR_CALLER_TIMEOUT_EN, SHALL have no watchdog logic, and timeout_err SHALL be tied to 0.

Structure
REQ-032 Package generator_caller_pkg SHALL hold the FSM state enum and the yield-pair struct typedef.
REQ-033 The FIFO SHALL be the sub-module generator_caller_fifo, parameterised by WIDTH and DEPTH.

Verification
REQ-034 Args 1,2,3,4; the model yields (1,2),(3,4),(5,6) then raises _done; res_ready=1 -> res stream (1,2),(3,4),(5,6), yield_count=3, one call_done, a..d=1,2,3,4 held.
REQ-035 res_ready=0 while the model offers 6 yields with DEPTH=4 -> _ready falls after 4 pushes; after res_ready=1, all 6 values arrive in order with none lost.
REQ-036 The model asserts _valid with (7,8) and _done in the same cycle -> (7,8) is delivered, yield_count=1, call_done follows the pop.
REQ-037 _reset_n low two cycles after _start -> all outputs reach reset values immediately, no call_done, and the next call works normally.
REQ-038 With GENERATOR_CALLER_TIMEOUT_EN, TIMEOUT_CYCLES=16, the model yields once then stalls -> timeout_err=1 after 16 idle cycles, call_done follows, and timeout_err clears on the next cmd.
